ibex_xif_result_tx: RTL and testbench

//  Coprocessor-side transmitter for the XIF result channel. The core's writeback stage is the receiver.

---
 rtl/ibex_xif_result_tx_if.sv | 33 +++
 rtl/ibex_xif_result_tx.sv | 176 +++++++++++++++++
 tb/tb_ibex_xif_result_tx.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_xif_result_tx_if.sv
// XIF result-style valid/ready channel carrying one coprocessor result.
// Used both for the coprocessor-side input and the core-facing output.
interface ibex_xif_result_tx_if #(
    parameter int unsigned IdWidth = 4
) ();
    logic               valid;
    logic               ready;
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic [31:0]        data;
    logic               we;
    logic               exc;

    modport master (
        output valid,
        output id,
        output rd,
        output data,
        output we,
        output exc,
        input  ready
    );

    modport slave (
        input  valid,
        input  id,
        input  rd,
        input  data,
        input  we,
        input  exc,
        output ready
    );
endinterface

// File: rtl/ibex_xif_result_tx.sv
// In-order result buffer for the XIF result channel.
// Entries leave once their ID is committed (sent) or killed (dropped).
module ibex_xif_result_tx #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    ibex_xif_result_tx_if.slave      res,
    input  logic                     commit_valid_i,
    input  logic [IdWidth-1:0]       commit_id_i,
    input  logic                     commit_kill_i,
    ibex_xif_result_tx_if.master     result,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW   = $clog2(Depth);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned NumIds = 2 ** IdWidth;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [4:0]         rd;
        logic [31:0]        data;
        logic               we;
        logic               exc;
    } entry_t;

    typedef enum logic [1:0] {
        HeadEmpty,
        HeadWait,
        HeadPresent,
        HeadDrop
    } head_e;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wptr_q;
    logic [PtrW-1:0]   rptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [NumIds-1:0] seen_q;
    logic [NumIds-1:0] seen_d;
    logic [NumIds-1:0] kill_q;
    logic [NumIds-1:0] kill_d;

    entry_t head;
    entry_t wr_entry;
    entry_t out;
    head_e  head_state;
    logic   empty;
    logic   full;
    logic   push;
    logic   pop;
    logic   xfer;
    logic   drop;
    logic   clr_same;
    logic   commit_ok;
    logic   id_inflight;

    function automatic logic [PtrW-1:0] slot_off(
        input logic [PtrW-1:0] slot,
        input logic [PtrW-1:0] rptr
    );
        slot_off = slot - rptr;
    endfunction

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CntW'(Depth));
    assign res.ready = ~full;
    assign push      = res.valid & ~full;
    assign head      = mem_q[rptr_q];
    assign count_o   = cnt_q;

    assign wr_entry.id   = res.id;
    assign wr_entry.rd   = res.rd;
    assign wr_entry.data = res.data;
    assign wr_entry.we   = res.we;
    assign wr_entry.exc  = res.exc;

    // Head disposition, derived from registered FIFO and status state only.
    always_comb begin
        head_state = HeadEmpty;
        unique case (1'b1)
            empty:
                head_state = HeadEmpty;
            !empty && !seen_q[head.id]:
                head_state = HeadWait;
            !empty && seen_q[head.id] && !kill_q[head.id]:
                head_state = HeadPresent;
            default:
                head_state = HeadDrop;
        endcase
    end

    assign xfer = (head_state == HeadPresent) & result.ready;
    assign drop = (head_state == HeadDrop);
    assign pop  = xfer | drop;

    assign clr_same  = pop & (head.id == commit_id_i);
    assign commit_ok = commit_valid_i & (~seen_q[commit_id_i] | clr_same);

    // A commit landing on the entry being retired re-arms it.
    always_comb begin
        seen_d = seen_q;
        kill_d = kill_q;
        if (pop) begin
            seen_d[head.id] = 1'b0;
            kill_d[head.id] = 1'b0;
        end
        if (commit_ok) begin
            seen_d[commit_id_i] = 1'b1;
            kill_d[commit_id_i] = commit_kill_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            seen_q <= '0;
            kill_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
            seen_q <= seen_d;
            kill_q <= kill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    assign result.valid = (head_state == HeadPresent);
    assign out          = result.valid ? head : '0;
    assign result.id    = out.id;
    assign result.rd    = out.rd;
    assign result.data  = out.data;
    assign result.we    = out.we;
    assign result.exc   = out.exc;

    always_comb begin
        id_inflight = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (({1'b0, slot_off(PtrW'(i), rptr_q)} < cnt_q)
                && (mem_q[i].id == res.id)) begin
                id_inflight = 1'b1;
            end
        end
    end

    a_commit_dup: assert property (
        @(posedge clk_i) disable iff (rst_i)
        commit_valid_i |-> commit_ok
    );

    a_dup_inflight: assert property (
        @(posedge clk_i) disable iff (rst_i)
        push |-> !id_inflight
    );

    a_valid_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        result.valid && !result.ready |=> result.valid && $stable(out)
    );
endmodule

// File: tb/tb_ibex_xif_result_tx.sv
// Randomized bench for ibex_xif_result_tx against a queue-based model.
// Directed scenarios pin the model; a per-cycle compare checks the DUT.
module tb_ibex_xif_result_tx;
    localparam int Depth = 4;
    localparam int IdW   = 4;
    localparam int NIds  = 16;

    typedef struct {
        int          id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        exc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cv;
    logic [3:0] cid;
    logic       ck;
    logic [2:0] count;

    ibex_xif_result_tx_if #(.IdWidth(IdW)) res_if ();
    ibex_xif_result_tx_if #(.IdWidth(IdW)) result_if ();

    ibex_xif_result_tx #(
        .Depth   (Depth),
        .IdWidth (IdW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .res            (res_if),
        .commit_valid_i (cv),
        .commit_id_i    (cid),
        .commit_kill_i  (ck),
        .result         (result_if),
        .count_o        (count)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   mseen[NIds];
    bit   mkill[NIds];
    int   emit_id[$];
    int   emit_cyc[$];
    int   cyc;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    function automatic bit inq(int id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        return mseen[mq[0].id] && !mkill[mq[0].id];
    endfunction

    function automatic bit m_drop();
        if (mq.size() == 0) return 1'b0;
        return mseen[mq[0].id] && mkill[mq[0].id];
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [43:0] expp;
        logic [43:0] actp;
        if (chk_en) begin
            check("count", 64'(count), 64'(mq.size()));
            check("res_ready", 64'(res_if.ready), 64'(mq.size() < Depth));
            expp = '0;
            if (m_valid()) begin
                expp = {1'b1, 4'(mq[0].id), mq[0].rd, mq[0].data,
                        mq[0].we, mq[0].exc};
            end
            actp = {result_if.valid, result_if.id, result_if.rd,
                    result_if.data, result_if.we, result_if.exc};
            check("result", 64'(actp), 64'(expp));
        end
    end

    // Advance one clock; the model consumes the inputs the DUT sampled.
    task automatic step();
        bit   s_rst = rst;
        bit   s_rv  = res_if.valid;
        bit   s_cv  = cv;
        int   s_cid = int'(cid);
        bit   s_ck  = ck;
        bit   s_rr  = result_if.ready;
        bit   s_val;
        bit   s_rdy;
        bit   s_pop;
        bit   ok;
        ent_t e;
        e.id   = int'(res_if.id);
        e.rd   = res_if.rd;
        e.data = res_if.data;
        e.we   = res_if.we;
        e.exc  = res_if.exc;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            mq.delete();
            foreach (mseen[i]) begin
                mseen[i] = 1'b0;
                mkill[i] = 1'b0;
            end
            return;
        end
        s_val = m_valid();
        s_rdy = mq.size() < Depth;
        s_pop = (s_val && s_rr) || m_drop();
        if (s_val && s_rr) begin
            emit_id.push_back(mq[0].id);
            emit_cyc.push_back(cyc);
        end
        ok = s_cv && (!mseen[s_cid] || (s_pop && mq[0].id == s_cid));
        if (s_pop) begin
            mseen[mq[0].id] = 1'b0;
            mkill[mq[0].id] = 1'b0;
            void'(mq.pop_front());
        end
        if (ok) begin
            mseen[s_cid] = 1'b1;
            mkill[s_cid] = s_ck;
        end
        if (s_rv && s_rdy) mq.push_back(e);
    endtask

    task automatic idle();
        rst             = 1'b0;
        res_if.valid    = 1'b0;
        res_if.id       = '0;
        res_if.rd       = '0;
        res_if.data     = '0;
        res_if.we       = 1'b0;
        res_if.exc      = 1'b0;
        cv              = 1'b0;
        cid             = '0;
        ck              = 1'b0;
        result_if.ready = 1'b0;
    endtask

    task automatic put(int id, logic [31:0] data);
        res_if.valid = 1'b1;
        res_if.id    = 4'(id);
        res_if.rd    = 5'($urandom);
        res_if.data  = data;
        res_if.we    = 1'($urandom);
        res_if.exc   = 1'($urandom);
    endtask

    task automatic commit(int id, bit kill);
        cv  = 1'b1;
        cid = 4'(id);
        ck  = kill;
    endtask

    initial begin
        int b;
        bit rr;
        bit pp;
        int pid;
        int id;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        chk_en = 1'b0;
        idle();
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_res_ready", 64'(res_if.ready), 64'd1);
        check("rst_valid", 64'(result_if.valid), 64'd0);
        check("rst_data", 64'(result_if.data), 64'd0);
        rst = 1'b0;

        put(3, 32'hDEADBEEF); step(); idle();
        commit(3, 1'b0); step(); idle();
        check("t1_valid", 64'(result_if.valid), 64'd1);
        check("t1_id", 64'(result_if.id), 64'd3);
        check("t1_data", 64'(result_if.data), 64'hDEADBEEF);
        check("t1_count1", 64'(count), 64'd1);
        result_if.ready = 1'b1; step(); idle();
        check("t1_count0", 64'(count), 64'd0);
        check("t1_valid0", 64'(result_if.valid), 64'd0);

        commit(5, 1'b0); step(); idle(); step();
        put(5, 32'h5555_0005); step(); idle();
        check("t2_valid", 64'(result_if.valid), 64'd1);
        check("t2_id", 64'(result_if.id), 64'd5);
        result_if.ready = 1'b1; step(); idle();
        check("t2_count0", 64'(count), 64'd0);
        put(5, 32'h5555_0006); step(); idle(); step();
        check("t2_cleared", 64'(result_if.valid), 64'd0);
        check("t2_wait_cnt", 64'(count), 64'd1);
        commit(5, 1'b1); step(); idle(); step();
        check("t2_dropped", 64'(count), 64'd0);

        b = emit_id.size();
        result_if.ready = 1'b1;
        put(1, 32'h1); step();
        put(2, 32'h2); step();
        put(3, 32'h3); step();
        res_if.valid = 1'b0;
        commit(1, 1'b1); step();
        commit(2, 1'b0); step();
        commit(3, 1'b0); step();
        cv = 1'b0;
        step(); step(); step();
        idle();
        check("t3_n_emit", 64'(emit_id.size() - b), 64'd2);
        if (emit_id.size() - b == 2) begin
            check("t3_first", 64'(emit_id[b]), 64'd2);
            check("t3_second", 64'(emit_id[b+1]), 64'd3);
            check("t3_b2b", 64'(emit_cyc[b+1] - emit_cyc[b]), 64'd1);
        end

        b = emit_id.size();
        for (int i = 0; i < 4; i++) begin
            put(i, 32'hA000_0000 + i); step();
        end
        res_if.valid = 1'b0;
        check("t4_full_ready", 64'(res_if.ready), 64'd0);
        check("t4_full_count", 64'(count), 64'd4);
        commit(0, 1'b0); step(); cv = 1'b0;
        result_if.ready = 1'b1;
        put(9, 32'h9999_9999); step();
        check("t4_after_pop_cnt", 64'(count), 64'd3);
        check("t4_after_pop_rdy", 64'(res_if.ready), 64'd1);
        result_if.ready = 1'b0;
        put(4, 32'h0000_0044); step(); res_if.valid = 1'b0;
        check("t4_wrap_count", 64'(count), 64'd4);
        result_if.ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            commit(i, 1'b0); step();
        end
        cv = 1'b0;
        step(); step();
        idle();
        check("t4_n_emit", 64'(emit_id.size() - b), 64'd5);
        if (emit_id.size() - b == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t4_order", 64'(emit_id[b+i]), 64'(i));
            end
        end

        b = emit_id.size();
        put(7, 32'h7777_0007); step(); idle();
        commit(7, 1'b0); step(); idle();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t5_hold_valid", 64'(result_if.valid), 64'd1);
            check("t5_hold_data", 64'(result_if.data), 64'h7777_0007);
        end
        result_if.ready = 1'b1; step(); idle();
        check("t5_count0", 64'(count), 64'd0);
        check("t5_single", 64'(emit_id.size() - b), 64'd1);

        put(10, 32'hA); step();
        put(11, 32'hB); step();
        put(12, 32'hC); step();
        idle();
        commit(13, 1'b0); step();
        commit(14, 1'b0); step();
        idle();
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid", 64'(result_if.valid), 64'd0);
        check("t6_ready", 64'(res_if.ready), 64'd1);
        put(13, 32'hD); step(); idle(); step(); step();
        check("t6_stale", 64'(result_if.valid), 64'd0);
        commit(13, 1'b1); step(); idle(); step();
        check("t6_drained", 64'(count), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 499) == 0);
            rr  = ($urandom_range(0, 3) != 0);
            result_if.ready = rr;
            pp = (m_valid() && rr) || m_drop();
            if (mq.size() < Depth && $urandom_range(0, 1) == 1) begin
                for (int a = 0; a < 16; a++) begin
                    pid = $urandom_range(0, NIds - 1);
                    if (!inq(pid)) begin
                        put(pid, $urandom);
                        break;
                    end
                end
            end
            if (pp && $urandom_range(0, 7) == 0) begin
                commit(mq[0].id, $urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 2) == 0) begin
                for (int a = 0; a < 16; a++) begin
                    id = $urandom_range(0, NIds - 1);
                    if (!mseen[id]) begin
                        commit(id, $urandom_range(0, 9) < 3);
                        break;
                    end
                end
            end
            step();
        end
        idle();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
